// File: rtl/hash_link_pkg.sv
// Shared definitions for the hash link: frame geometry and receiver state encoding.
// Also used on the transmitter side, so keep encodings stable.
package hash_link_pkg;

   localparam int HASH_BYTES = 8;
   localparam int HASH_W     = 8 * HASH_BYTES;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RECV  = 2'd2;
   localparam logic [1:0] ST_TAIL  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ARMED = ST_ARMED,
      RECV  = ST_RECV,
      TAIL  = ST_TAIL
   } link_state_t;

endpackage

// File: rtl/hash_byte_assembler.sv
// Shift register and byte counter that build a hash word, LSB byte first.
// The counter wraps to zero after the final byte so a new frame starts clean.
module hash_byte_assembler #(
   parameter int NUM_BYTES = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   shift_en,
   input  logic                   clear,
   input  logic [7:0]             data,
   output logic [8*NUM_BYTES-1:0] word,
   output logic                   last_byte
);

   localparam int W     = 8 * NUM_BYTES;
   localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   logic [W-1:0]     shreg;
   logic [CNT_W-1:0] cnt;

   assign word      = shreg;
   assign last_byte = (cnt == CNT_W'(NUM_BYTES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (shift_en) begin
         // New byte enters at the top, so byte i ends in bits [8i+7:8i].
         shreg <= {data, shreg[W-1:8]};
         cnt   <= last_byte ? '0 : cnt + 1'b1;
      end else if (clear) begin
         cnt   <= '0;
      end
   end

endmodule

// File: rtl/hash_receiver.sv
// Receive-side partner of the string checker: arms on z2, captures hash bytes while z1 is high,
// publishes completed hashes, flags key matches, counts good frames and reports malformed ones.
module hash_receiver
   import hash_link_pkg::*;
#(
   parameter int                      NUM_BYTES = HASH_BYTES,
   parameter logic [8*NUM_BYTES-1:0]  KEY       = '0,
   parameter int                      COUNT_W   = 8
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [7:0]             hashData,
   input  logic                   z1,
   input  logic                   z2,
   output logic [8*NUM_BYTES-1:0] hashWord,
   output logic                   hashReady,
   output logic                   matchFound,
   output logic                   frameError,
   output logic [COUNT_W-1:0]     wordCount,
   output logic [1:0]             fsm_state
);

   localparam int W = 8 * NUM_BYTES;

   link_state_t  state;
   logic         shift_en;
   logic         clear;
   logic         last_byte;
   logic [W-1:0] asm_word;
   logic [W-1:0] assembled;

   assign fsm_state = state;
   assign shift_en  = z1 && ((state == ARMED) || (state == RECV));
   assign clear     = (state == IDLE) || (state == TAIL) || ((state == RECV) && !z1);
   // Complete word including the byte being captured on this edge.
   assign assembled = {hashData, asm_word[W-1:8]};

   hash_byte_assembler #(
      .NUM_BYTES (NUM_BYTES)
   ) u_assembler (
      .clk       (Clock),
      .rst       (Reset),
      .shift_en  (shift_en),
      .clear     (clear),
      .data      (hashData),
      .word      (asm_word),
      .last_byte (last_byte)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         hashWord   <= '0;
         hashReady  <= 1'b0;
         matchFound <= 1'b0;
         frameError <= 1'b0;
         wordCount  <= '0;
      end else begin
         hashReady  <= 1'b0;
         matchFound <= 1'b0;
         frameError <= 1'b0;
         case (state)
            IDLE: begin
               // Transmit without a preceding alert is an orphan, even if z2 is also high.
               if (z1) begin
                  frameError <= 1'b1;
                  state      <= TAIL;
               end else if (z2) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (z1) state <= RECV;
            end
            RECV: begin
               if (z1) begin
                  if (last_byte) begin
                     hashWord   <= assembled;
                     hashReady  <= 1'b1;
                     matchFound <= (assembled == KEY);
                     if (wordCount != '1) wordCount <= wordCount + 1'b1;
                     state      <= TAIL;
                  end
               end else begin
                  frameError <= 1'b1;
                  state      <= IDLE;
               end
            end
            TAIL: begin
               if (!z1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_receiver.sv
// Directed bench for hash_receiver: reset, nominal and matching frames, truncation,
// orphan transmit, long tails, reset mid-frame and count saturation.
module tb_hash_receiver;
   import hash_link_pkg::*;

   localparam logic [63:0] KEY_VAL = 64'h0807060504030201;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [7:0]  hashData = 8'h00;
   logic        z1 = 1'b0;
   logic        z2 = 1'b0;
   logic [63:0] hashWord;
   logic        hashReady;
   logic        matchFound;
   logic        frameError;
   logic [7:0]  wordCount;
   logic [1:0]  fsm_state;

   int total  = 0;
   int passed = 0;
   int rdy_cnt, match_cnt, err_cnt;

   hash_receiver #(
      .NUM_BYTES (8),
      .KEY       (KEY_VAL),
      .COUNT_W   (8)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .hashData   (hashData),
      .z1         (z1),
      .z2         (z2),
      .hashWord   (hashWord),
      .hashReady  (hashReady),
      .matchFound (matchFound),
      .frameError (frameError),
      .wordCount  (wordCount),
      .fsm_state  (fsm_state)
   );

   always #5 Clock = ~Clock;

   // Advance one edge, then sample registered outputs and tally pulses.
   task automatic tick();
      @(posedge Clock);
      #1;
      if (hashReady)  rdy_cnt++;
      if (matchFound) match_cnt++;
      if (frameError) err_cnt++;
   endtask

   task automatic clr_counts();
      rdy_cnt = 0; match_cnt = 0; err_cnt = 0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // z2 alert, then all bytes with z1 high, then extra trailing z1 cycles, then idle.
   task automatic send_frame(input logic [63:0] w, input int extra);
      z2 = 1'b1; z1 = 1'b0;
      tick();
      z2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         z1 = 1'b1;
         hashData = w[8*i +: 8];
         tick();
      end
      for (int i = 0; i < extra; i++) begin
         hashData = 8'($urandom_range(0, 255));
         tick();
      end
      z1 = 1'b0;
      hashData = 8'h00;
      tick();
      tick();
   endtask

   initial begin
      // T1 reset with random inputs
      Reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         z1 = 1'($urandom_range(0, 1));
         z2 = 1'($urandom_range(0, 1));
         hashData = 8'($urandom_range(0, 255));
         tick();
      end
      Reset = 1'b0; z1 = 1'b0; z2 = 1'b0; hashData = 8'h00;
      check("reset_hashWord",   hashWord,   64'h0);
      check("reset_hashReady",  64'(hashReady),  64'h0);
      check("reset_matchFound", 64'(matchFound), 64'h0);
      check("reset_frameError", 64'(frameError), 64'h0);
      check("reset_wordCount",  64'(wordCount),  64'h0);
      check("reset_state",      64'(fsm_state),  64'(ST_IDLE));
      tick();

      // T2/T3 nominal frame equal to KEY
      clr_counts();
      send_frame(64'h0807060504030201, 0);
      check("t2_hashWord",   hashWord,   64'h0807060504030201);
      check("t2_ready_cnt",  64'(rdy_cnt),   64'd1);
      check("t2_wordCount",  64'(wordCount), 64'd1);
      check("t2_err_cnt",    64'(err_cnt),   64'd0);
      check("t3_match_cnt",  64'(match_cnt), 64'd1);

      // T3 non-matching frame
      clr_counts();
      send_frame(64'h1817161514131211, 0);
      check("t3b_hashWord",  hashWord,   64'h1817161514131211);
      check("t3b_match_cnt", 64'(match_cnt), 64'd0);
      check("t3b_ready_cnt", 64'(rdy_cnt),   64'd1);
      check("t3b_wordCount", 64'(wordCount), 64'd2);

      // T4 truncated frame: 3 bytes then z1 drops
      clr_counts();
      z2 = 1'b1; tick(); z2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         z1 = 1'b1; hashData = 8'hA0 + 8'(i); tick();
      end
      z1 = 1'b0; hashData = 8'h00;
      tick();
      check("t4_err_pulse",  64'(frameError), 64'h1);
      tick();
      check("t4_err_cnt",    64'(err_cnt),   64'd1);
      check("t4_ready_cnt",  64'(rdy_cnt),   64'd0);
      check("t4_hashWord",   hashWord,   64'h1817161514131211);
      check("t4_wordCount",  64'(wordCount), 64'd2);
      check("t4_state",      64'(fsm_state), 64'(ST_IDLE));

      // T5 orphan transmit with z2 also high on the first cycle
      clr_counts();
      for (int i = 0; i < 4; i++) begin
         z1 = 1'b1; z2 = (i == 0); hashData = 8'h55; tick();
      end
      z1 = 1'b0; z2 = 1'b0; tick(); tick();
      check("t5_err_cnt",    64'(err_cnt),   64'd1);
      check("t5_ready_cnt",  64'(rdy_cnt),   64'd0);
      check("t5_state",      64'(fsm_state), 64'(ST_IDLE));
      check("t5_wordCount",  64'(wordCount), 64'd2);

      // T5 frame with two trailing z1 cycles
      clr_counts();
      send_frame(64'h2827262524232221, 2);
      check("t5b_ready_cnt", 64'(rdy_cnt),   64'd1);
      check("t5b_err_cnt",   64'(err_cnt),   64'd0);
      check("t5b_hashWord",  hashWord,   64'h2827262524232221);
      check("t5b_wordCount", 64'(wordCount), 64'd3);

      // T6 reset at byte 5 discards the frame quietly
      clr_counts();
      z2 = 1'b1; tick(); z2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         z1 = 1'b1; hashData = 8'hC0 + 8'(i); tick();
      end
      Reset = 1'b1; tick();
      Reset = 1'b0; z1 = 1'b0; hashData = 8'h00; tick();
      check("t6_rst_err_cnt",  64'(err_cnt),   64'd0);
      check("t6_rst_hashWord", hashWord,   64'h0);
      check("t6_rst_count",    64'(wordCount), 64'd0);
      check("t6_rst_state",    64'(fsm_state), 64'(ST_IDLE));
      clr_counts();
      send_frame(64'h0807060504030201, 0);
      check("t6_hashWord",   hashWord,   64'h0807060504030201);
      check("t6_wordCount",  64'(wordCount), 64'd1);
      check("t6_ready_cnt",  64'(rdy_cnt),   64'd1);

      // T6 saturation: 253 more frames reach 0xFE, 47 more stick at 0xFF
      for (int f = 0; f < 253; f++) send_frame(64'h1111111111111111 * 64'(f % 7 + 1), 0);
      check("t6_count_fe", 64'(wordCount), 64'hFE);
      for (int f = 0; f < 47; f++) send_frame(64'h0102030405060708, 0);
      check("t6_count_ff", 64'(wordCount), 64'hFF);
      check("t6_sat_hashWord", hashWord, 64'h0102030405060708);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
